uart_tx_8n1: RTL

// - UART transmitter, 8 data bits, no parity, 1 stop bit (8N1), LSB first.
// - Serves the UART TX side of puf_module on the iCE40HX8K board.
// - Accepts one byte per tx_enable handshake, serialises it onto the FPGA->USB-serial

---
 rtl/uart_tx_8n1.sv | 116 +++++++++++
 1 files changed

// File: rtl/uart_tx_8n1.sv
// UART transmitter, 8 data bits, no parity, one stop bit, LSB first.
// One byte is accepted per tx_enable request while idle. The byte is
// serialised on a registered, glitch-free line. tx_ready reports when the
// transmitter is idle and can take a byte.
//
// Handshake: a byte is accepted on the rising edge where the FSM is IDLE and
// tx_enable=1. tx_ready = IDLE & ~tx_enable. It drops in the same cycle that
// a request is raised. A request made outside IDLE is dropped silently.
// Clients must not derive tx_enable combinationally from tx_ready.
module uart_tx_8n1 #(
  parameter int CLK_FREQ     = 12000000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_enable,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx,
  output logic [1:0] o_dbg_state
);

  // With fewer than two clocks per bit, the bit timing cannot be built.
  if (CLKS_PER_BIT < 2) begin : g_cpb_check
    $error("uart_tx_8n1: CLKS_PER_BIT must be >= 2");
  end

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic          r_tx;
  logic          w_bit_end;

  // A bit period ends when the baud counter reaches its last count.
  assign w_bit_end = (r_cnt == LAST_CNT);

  // The only combinational output. It drops as soon as a request is raised.
  assign tx_ready    = (r_state == S_IDLE) & ~tx_enable;
  assign tx          = r_tx;
  assign o_dbg_state = r_state;

  // Frame sequencer: the baud counter, the bit index, the shift register and the registered line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx  <= 1'b1;
          r_cnt <= '0;
          if (tx_enable) begin
            r_shift <= tx_data;
            r_state <= S_START;
            r_tx    <= 1'b0;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_state <= S_DATA;
            r_tx    <= r_shift[0];
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_shift <= {1'b0, r_shift[7:1]};
            if (r_idx == 3'd7) begin
              r_state <= S_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_idx <= r_idx + 3'd1;
              r_tx  <= r_shift[1];
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
            r_tx    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule
